// File: rtl/div_pkg.sv
// Shared types and defaults for the restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   prem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   prem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] trial_c;

    // Partial remainder stays below the divisor, so the widened trial value never wraps.
    always_comb begin
        trial_c = {prem_i, bit_i};
        q_o     = (trial_c >= (WIDTH+2)'(div_i));
        prem_o  = q_o ? (WIDTH+1)'(trial_c - (WIDTH+2)'(div_i))
                      : (WIDTH+1)'(trial_c);
    end

endmodule

// File: rtl/divider.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Define DIVIDER_SIGNED_EN to add the is_signed input for truncating signed division.
module divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIVIDER_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             valid_out,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    div_state_t       state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   prem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             accept_c;
    logic             sgn_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   prem_c;
    logic             qbit_c;
    logic [WIDTH-1:0] quo_raw_c;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] rem_d;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem_i (prem_q),
        .div_i  (dvs_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .prem_o (prem_c),
        .q_o    (qbit_c)
    );

    // Operand magnitudes at accept and sign-corrected results on the final step.
    always_comb begin
        sgn_c = 1'b0;
`ifdef DIVIDER_SIGNED_EN
        sgn_c = is_signed;
`endif
        accept_c  = valid_in && (state_q != BUSY);
        a_mag_c   = (sgn_c && a[WIDTH-1]) ? -a : a;
        b_mag_c   = (sgn_c && b[WIDTH-1]) ? -b : b;
        quo_raw_c = WIDTH'({dvd_q, qbit_c});
        quo_d     = neg_quo_q ? -quo_raw_c : quo_raw_c;
        rem_d     = neg_rem_q ? -prem_c[WIDTH-1:0] : prem_c[WIDTH-1:0];
    end

    // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy        <= 1'b0;
            valid_out   <= 1'b0;
            q           <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state_q)
                BUSY: begin
                    prem_q <= prem_c;
                    dvd_q  <= quo_raw_c;
                    cnt_q  <= cnt_q + WIDTH'(1);
                    if (cnt_q == WIDTH'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        busy        <= 1'b0;
                        valid_out   <= 1'b1;
                        q           <= quo_d;
                        rem         <= rem_d;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    if (accept_c) begin
                        dvd_q     <= a_mag_c;
                        dvs_q     <= b_mag_c;
                        prem_q    <= '0;
                        cnt_q     <= '0;
                        neg_quo_q <= sgn_c && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_q <= sgn_c && a[WIDTH-1];
                        if (b == '0) begin
                            state_q     <= DONE;
                            valid_out   <= 1'b1;
                            q           <= '1;
                            rem         <= a;
                            div_by_zero <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            busy    <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the restoring divider; signed vectors run when DIVIDER_SIGNED_EN is defined.
module tb_divider;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         valid_out;
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         div_by_zero;
`ifdef DIVIDER_SIGNED_EN
    logic         is_signed;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .a           (a),
        .b           (b),
`ifdef DIVIDER_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .busy        (busy),
        .valid_out   (valid_out),
        .q           (q),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
        valid_in = 1'b1;
        a        = av;
        b        = bv;
        tick();
        valid_in = 1'b0;
    endtask

    // Counts edges after the accepting edge until valid_out; optionally pulses valid_in mid-flight.
    task automatic wait_valid(input int pulse_at, output int lat, output int bcnt, output bit hidden_ok);
        logic [W-1:0] q0;
        logic [W-1:0] r0;
        q0        = q;
        r0        = rem;
        lat       = 0;
        bcnt      = 0;
        hidden_ok = 1'b1;
        while (!valid_out && lat < 100) begin
            if (busy) bcnt++;
            if (q !== q0 || rem !== r0) hidden_ok = 1'b0;
            if (lat == pulse_at) begin
                valid_in = 1'b1;
                a        = 32'd1000;
                b        = 32'd9;
            end
            tick();
            valid_in = 1'b0;
            lat++;
        end
        if (!valid_out) lat = -1;
    endtask

    task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input int pulse_at, input logic [W-1:0] eq, input logic [W-1:0] er,
                      input logic edz, input int elat);
        int lat;
        int bcnt;
        bit hidden_ok;
        start(av, bv);
        wait_valid(pulse_at, lat, bcnt, hidden_ok);
        check({tag, ".lat"},    64'(lat),         64'(elat));
        check({tag, ".busy"},   64'(bcnt),        64'(elat));
        check({tag, ".hidden"}, 64'(hidden_ok),   64'(1));
        check({tag, ".q"},      64'(q),           64'(eq));
        check({tag, ".rem"},    64'(rem),         64'(er));
        check({tag, ".dbz"},    64'(div_by_zero), 64'(edz));
    endtask

    initial begin
        int vcount;
        rst      = 1'b1;
        valid_in = 1'b1;
        a        = 32'd100;
        b        = 32'd7;
`ifdef DIVIDER_SIGNED_EN
        is_signed = 1'b0;
`endif
        tick();
        tick();
        check("rst.busy",  64'(busy),        64'(0));
        check("rst.valid", 64'(valid_out),   64'(0));
        check("rst.q",     64'(q),           64'(0));
        check("rst.rem",   64'(rem),         64'(0));
        check("rst.dbz",   64'(div_by_zero), 64'(0));
        valid_in = 1'b0;
        rst      = 1'b0;
        tick();

        op("d100_7", 32'd100, 32'd7, -1, 32'd14, 32'd2, 1'b0, 32);
        tick();
        check("d100_7.strobe", 64'(valid_out), 64'(0));
        check("d100_7.hold_q", 64'(q),         64'(14));
        tick();

        op("d5_0", 32'd5, 32'd0, -1, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        tick();

        op("d3_10", 32'd3, 32'd10, 9, 32'd0, 32'd3, 1'b0, 32);
        op("d1000_9", 32'd1000, 32'd9, -1, 32'd111, 32'd1, 1'b0, 32);
        tick();

        op("d0_5", 32'd0, 32'd5, -1, 32'd0, 32'd0, 1'b0, 32);
        tick();

        op("dmax_1", 32'hFFFF_FFFF, 32'd1, -1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
        tick();

        // Abandon an operation with reset partway through.
        start(32'hFFFF_FFFF, 32'd1);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.busy",  64'(busy),        64'(0));
        check("midrst.valid", 64'(valid_out),   64'(0));
        check("midrst.q",     64'(q),           64'(0));
        check("midrst.rem",   64'(rem),         64'(0));
        check("midrst.dbz",   64'(div_by_zero), 64'(0));
        vcount = 0;
        repeat (40) begin
            tick();
            if (valid_out || busy) vcount++;
        end
        check("midrst.quiet", 64'(vcount), 64'(0));

`ifdef DIVIDER_SIGNED_EN
        is_signed = 1'b1;
        op("s_m7_2",   32'hFFFF_FFF9, 32'd2,        -1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
        tick();
        op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h8000_0000, 32'd0,        1'b0, 32);
        tick();
        op("s_7_m2",   32'd7,         32'hFFFF_FFFE, -1, 32'hFFFF_FFFD, 32'd1,        1'b0, 32);
        tick();
        op("s_m5_0",   32'hFFFF_FFFB, 32'd0,        -1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0);
        tick();
        is_signed = 1'b0;
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
